// File: rtl/mfu_accumulator_if.sv
// mfu_accumulator_if: product-beat input channel, result output channel and
// the sticky mode-error status of the mFU partial-sum accumulator.
// master = upstream mFU plus downstream requantisation stage, slave = accumulator.
interface mfu_accumulator_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_p;
    logic [1:0]       in_mode;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             err_mode;

    modport master (
        output in_valid, in_p, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, err_mode
    );

    modport slave (
        input  in_valid, in_p, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, err_mode
    );
endinterface

// File: rtl/mfu_accumulator.sv
// mfu_accumulator: decodes each 16-bit mFU product word into 1/2/4 signed
// lanes according to its mode, accumulates the lane sums into a dot product
// and hands the finished sum downstream through a valid/ready handshake.
// Optional feature macro: MFU_ACC_SAT_EN -- saturating accumulation instead
// of two's complement wrap-around.
module mfu_accumulator #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 10
) (
    input  logic                 clk,
    input  logic                 nrst,
    mfu_accumulator_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_nxt_s;
    logic        [CNT_W-1:0] cnt_r;
    logic        [CNT_W-1:0] cnt_nxt_s;

    logic                    in_ready_r;
    logic                    out_valid_r;
    logic signed [ACC_W-1:0] out_acc_r;
    logic        [CNT_W-1:0] out_cnt_r;
    logic                    err_mode_r;

    logic                    accept_s;
    logic                    counted_s;
    logic                    load_out_s;
    logic                    err_set_s;
    logic signed [15:0]      lane_sum_s;
    logic signed [ACC_W-1:0] lane_ext_s;

    // Sum of the signed lanes packed in one product word; mode 3 contributes nothing.
    function automatic logic signed [15:0] lane_sum_f(input logic [15:0] p, input logic [1:0] mode);
        logic signed [15:0] s;
        case (mode)
            2'd0:    s = signed'(p);
            2'd1:    s = 16'(signed'(p[15:8])) + 16'(signed'(p[7:0]));
            2'd2:    s = 16'(signed'(p[15:12])) + 16'(signed'(p[11:8]))
                       + 16'(signed'(p[7:4]))   + 16'(signed'(p[3:0]));
            default: s = 16'sd0;
        endcase
        return s;
    endfunction

    // One accumulate step: wraps, or clamps on true signed overflow when saturation is built in.
    function automatic logic signed [ACC_W-1:0] acc_add_f(input logic signed [ACC_W-1:0] a,
                                                          input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        s = a + b;
`ifdef MFU_ACC_SAT_EN
        if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            s = s;
        end
`endif
        return s;
    endfunction

    assign accept_s   = bus.in_valid & in_ready_r;
    assign counted_s  = (bus.in_mode != 2'd3);
    assign lane_sum_s = lane_sum_f(bus.in_p, bus.in_mode);
    assign lane_ext_s = ACC_W'(lane_sum_s);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: in_last closes a group, the output handshake reopens the input.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_ACC: begin
                if (accept_s) begin
                    state_nxt_s = bus.in_last ? ST_HOLD : ST_ACC;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next accumulator/count, result load strobe and mode-error strobe.
    always_comb begin
        acc_nxt_s  = acc_r;
        cnt_nxt_s  = cnt_r;
        load_out_s = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_ACC: begin
                if (accept_s) begin
                    acc_nxt_s = acc_add_f(acc_r, lane_ext_s);
                    if (counted_s && (cnt_r != {CNT_W{1'b1}})) begin
                        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                    load_out_s = bus.in_last;
                    err_set_s  = ~counted_s;
                end else begin
                    acc_nxt_s = acc_r;
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    acc_nxt_s = {ACC_W{1'b0}};
                    cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    acc_nxt_s = acc_r;
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                acc_nxt_s = {ACC_W{1'b0}};
                cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Datapath and registered outputs; the result holds until the next group closes.
    always_ff @(posedge clk) begin
        if (nrst) begin
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_acc_r   <= {ACC_W{1'b0}};
            out_cnt_r   <= {CNT_W{1'b0}};
            err_mode_r  <= 1'b0;
        end else begin
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_HOLD);
            out_valid_r <= (state_nxt_s == ST_HOLD);
            if (load_out_s) begin
                out_acc_r <= acc_nxt_s;
                out_cnt_r <= cnt_nxt_s;
            end else begin
                out_acc_r <= out_acc_r;
                out_cnt_r <= out_cnt_r;
            end
            err_mode_r  <= err_mode_r | err_set_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_acc   = out_acc_r;
    assign bus.out_cnt   = out_cnt_r;
    assign bus.err_mode  = err_mode_r;

endmodule

// File: tb/tb_mfu_accumulator.sv
// tb_mfu_accumulator: drives two accumulators (32-bit/10-bit count and
// 16-bit/4-bit count) with identical beats and compares both against an
// integer reference model of the lane decode and accumulation rules.
module tb_mfu_accumulator;

    localparam int AW_A = 32;
    localparam int CW_A = 10;
    localparam int AW_B = 16;
    localparam int CW_B = 4;

    logic clk = 1'b0;
    logic nrst;

    int n_checks = 0;
    int n_errors = 0;

    longint g_p[$];
    int     g_m[$];
    bit     err_exp;

    always #5 clk = ~clk;

    mfu_accumulator_if #(.ACC_W(AW_A), .CNT_W(CW_A)) if_a ();
    mfu_accumulator_if #(.ACC_W(AW_B), .CNT_W(CW_B)) if_b ();

    assign if_b.in_valid  = if_a.in_valid;
    assign if_b.in_p      = if_a.in_p;
    assign if_b.in_mode   = if_a.in_mode;
    assign if_b.in_last   = if_a.in_last;
    assign if_b.out_ready = if_a.out_ready;

    mfu_accumulator #(.ACC_W(AW_A), .CNT_W(CW_A)) dut_a (.clk(clk), .nrst(nrst), .bus(if_a.slave));
    mfu_accumulator #(.ACC_W(AW_B), .CNT_W(CW_B)) dut_b (.clk(clk), .nrst(nrst), .bus(if_b.slave));

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference lane decode from the word's numeric value.
    function automatic longint lane_val(input longint p, input int m);
        longint v;
        longint part;
        v = 0;
        if (m == 0) begin
            v = (p >= 32768) ? p - 65536 : p;
        end else if (m == 1) begin
            for (int k = 0; k < 2; k++) begin
                part = (p >> (8 * k)) & 255;
                v += (part >= 128) ? part - 256 : part;
            end
        end else if (m == 2) begin
            for (int k = 0; k < 4; k++) begin
                part = (p >> (4 * k)) & 15;
                v += (part >= 8) ? part - 16 : part;
            end
        end
        return v;
    endfunction

    function automatic longint model_acc(input int w);
        longint acc;
        longint hi;
        longint lo;
        longint span;
        acc  = 0;
        span = longint'(1) << w;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        foreach (g_p[i]) begin
            acc += lane_val(g_p[i], g_m[i]);
`ifdef MFU_ACC_SAT_EN
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
`else
            acc = acc & (span - 1);
            if (acc > hi) acc -= span;
`endif
        end
        return acc;
    endfunction

    function automatic longint model_cnt(input int c);
        longint n;
        n = 0;
        foreach (g_m[i]) if (g_m[i] != 3) n++;
        if (n > (longint'(1) << c) - 1) n = (longint'(1) << c) - 1;
        return n;
    endfunction

    task automatic check_hs(input string tag, input bit valid, input bit ready);
        check_val({tag, "_valid_a"}, longint'(if_a.out_valid), longint'(valid));
        check_val({tag, "_valid_b"}, longint'(if_b.out_valid), longint'(valid));
        check_val({tag, "_ready_a"}, longint'(if_a.in_ready), longint'(ready));
        check_val({tag, "_ready_b"}, longint'(if_b.in_ready), longint'(ready));
    endtask

    task automatic check_res(input string tag, input longint ea, input longint eb,
                             input longint ca, input longint cb);
        check_val({tag, "_acc_a"}, longint'($signed(if_a.out_acc)), ea);
        check_val({tag, "_acc_b"}, longint'($signed(if_b.out_acc)), eb);
        check_val({tag, "_cnt_a"}, longint'(if_a.out_cnt), ca);
        check_val({tag, "_cnt_b"}, longint'(if_b.out_cnt), cb);
        check_val({tag, "_err_a"}, longint'(if_a.err_mode), longint'(err_exp));
        check_val({tag, "_err_b"}, longint'(if_b.err_mode), longint'(err_exp));
    endtask

    task automatic add_beat(input longint p, input int m);
        g_p.push_back(p);
        g_m.push_back(m);
    endtask

    task automatic do_reset(input string tag);
        if_a.in_valid = 1'b0;
        if_a.in_last  = 1'b0;
        nrst = 1'b1;
        @(posedge clk); #1;
        nrst = 1'b0;
        err_exp = 1'b0;
        check_hs(tag, 1'b0, 1'b1);
        check_res(tag, 0, 0, 0, 0);
    endtask

    // Sends the queued beats as one group, holds the result for 'stall' extra cycles.
    task automatic run_group(input string tag, input int stall, input bit gaps);
        longint ea, eb, ca, cb;
        int n;
        n  = g_p.size();
        ea = model_acc(AW_A);
        eb = model_acc(AW_B);
        ca = model_cnt(CW_A);
        cb = model_cnt(CW_B);
        foreach (g_m[i]) if (g_m[i] == 3) err_exp = 1'b1;
        if_a.out_ready = (stall == 0);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(3) == 0)) begin
                if_a.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if_a.in_valid = 1'b1;
            if_a.in_p     = 16'(g_p[i]);
            if_a.in_mode  = 2'(g_m[i]);
            if_a.in_last  = (i == n - 1);
            check_hs({tag, "_beat"}, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        if_a.in_valid = 1'b0;
        if_a.in_last  = 1'b0;
        check_hs({tag, "_res"}, 1'b1, 1'b0);
        check_res({tag, "_res"}, ea, eb, ca, cb);
        for (int s = 0; s < stall; s++) begin
            if_a.in_valid = 1'b1;
            if_a.in_p     = 16'($urandom_range(0, 65535));
            if_a.in_mode  = 2'd0;
            if_a.in_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_hs({tag, "_stall"}, 1'b1, 1'b0);
            check_res({tag, "_stall"}, ea, eb, ca, cb);
        end
        if_a.in_valid  = 1'b0;
        if_a.in_last   = 1'b0;
        if_a.out_ready = 1'b1;
        @(posedge clk); #1;
        check_hs({tag, "_done"}, 1'b0, 1'b1);
        check_res({tag, "_done"}, ea, eb, ca, cb);
        g_p.delete();
        g_m.delete();
    endtask

    initial begin
        if_a.in_valid  = 1'b0;
        if_a.in_p      = 16'd0;
        if_a.in_mode   = 2'd0;
        if_a.in_last   = 1'b0;
        if_a.out_ready = 1'b1;
        err_exp        = 1'b0;
        nrst           = 1'b1;
        @(posedge clk); #1;
        do_reset("reset");

        for (int i = 0; i < 3; i++) add_beat(65536 - 300, 0);
        run_group("m0_neg", 0, 1'b0);

        add_beat(16'h03FE, 1);
        run_group("m1_single", 0, 1'b0);
        add_beat(16'h1F7E, 2);
        run_group("m2_single", 0, 1'b0);

        add_beat(16'h1234, 0);
        add_beat(16'h00F1, 1);
        run_group("backpressure", 4, 1'b0);

        add_beat(10, 0);
        add_beat(16'h7FFF, 3);
        add_beat(10, 0);
        run_group("mode3", 0, 1'b0);
        add_beat(16'h7FFF, 3);
        run_group("mode3_only", 1, 1'b0);

        add_beat(32767, 0);
        add_beat(32767, 0);
        run_group("overflow", 0, 1'b0);

        for (int i = 0; i < 20; i++) add_beat(16'h7777, 2);
        run_group("cnt_sat", 0, 1'b0);

        // Reset after two of three beats: partial sum and error flag are dropped.
        for (int i = 0; i < 2; i++) begin
            if_a.in_valid = 1'b1;
            if_a.in_p     = 16'd500;
            if_a.in_mode  = 2'd0;
            if_a.in_last  = 1'b0;
            @(posedge clk); #1;
        end
        do_reset("mid_reset");
        add_beat(7, 0);
        add_beat(8, 0);
        run_group("after_reset", 0, 1'b0);

        for (int g = 0; g < 30; g++) begin
            int len;
            int r;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                add_beat(longint'($urandom_range(0, 65535)), (r == 9) ? 3 : (r % 3));
            end
            run_group("random", $urandom_range(0, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
